uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Frame-level receive controller for the UART RX path.
- Synchronises the serial line and detects and qualifies the start bit.
- Enables the 8-bit paralleliser for the data phase, then checks the optional parity bit and the stop bit.
- Sits between the RX_tick oversampling generator and the paralleliser.
- Presents a registered byte with one-cycle valid/error strobes to the host side.

Parameters:
OVERSAMPLE, 16, RX_tick pulses per bit; mid-bit sample at tick index OVERSAMPLE/2-1 (7). Last tick of a bit is OVERSAMPLE-1 (15).
SYNC_STAGES, 2, flip-flop depth of the RX_IN synchroniser (minimum 2).

Ports:
CLK  in  1  system clock, single clock domain.
RST  in  1  asynchronous, active-low reset.
RX_IN  in  1  raw serial line, idle high, asynchronous to CLK.
RX_tick  in  1  one-CLK-wide oversample strobe.
PAR_EN  in  1  1 = parity bit present after data.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
PARALLELISER_DONE  in  1  paralleliser completion flag.
PARALLEL_DATA  in  8  paralleliser output byte.
SER_BIT  out  1  synchronised RX line; drives paralleliser SER_DATA.
DESER_EN  out  1  paralleliser enable.
RX_DATA  out  8  received byte, registered.
DATA_VALID  out  1  one-cycle strobe: good frame, RX_DATA updated.
PAR_ERR  out  1  one-cycle strobe: parity mismatch.
STP_ERR  out  1  one-cycle strobe: stop bit sampled 0.
BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST low, async): state IDLE; tick_cnt 0; synchroniser flops 1; SER_BIT 1; all other outputs 0, including RX_DATA 0x00.
- RX_IN passes through SYNC_STAGES flops to give SER_BIT. Falling-edge detect compares SER_BIT with its 1-cycle delayed copy.
- tick_cnt (4 bits) increments only on RX_tick. It clears on every state transition. Without RX_tick, all state holds.
- IDLE: a falling edge on SER_BIT moves to START.
  - PAR_EN and PAR_TYP are latched on this transition and are used for the whole frame. Mid-frame changes are ignored.
- START:
  - At RX_tick with tick_cnt==7: if SER_BIT==1 (glitch), return to IDLE with no strobe.
  - At RX_tick with tick_cnt==15: go to DATA. DESER_EN rises in the same cycle as the transition.
- DATA:
  - DESER_EN is held 1.
  - On the first cycle PARALLELISER_DONE==1: latch RX_DATA<=PARALLEL_DATA and drop DESER_EN. Go to PARITY if PAR_EN_latched, else STOP.
  - While in DATA, PARALLELISER_DONE is the only exit condition; tick_cnt is unused.
- PARITY:
  - Expected parity = XOR of RX_DATA when even, XNOR of RX_DATA when odd.
  - At tick_cnt==7: compare SER_BIT with expected parity and latch par_bad.
  - At tick_cnt==15: go to STOP.
- STOP:
  - At tick_cnt==7: latch stp_bad = ~SER_BIT and go to DONE immediately, without waiting for the end of the bit, so back-to-back frames are supported.
- DONE (exactly 1 CLK):
  - DATA_VALID = ~par_bad & ~stp_bad.
  - PAR_ERR = par_bad; STP_ERR = stp_bad. Both errors may assert together.
  - Then go to IDLE. par_bad and stp_bad clear.
- Line break (stop=0, line stays low): no new START until SER_BIT has been seen high again. This follows from edge detection and must not be bypassed.
- Falling edge during STOP/DONE: ignored. Detection is armed only in IDLE, and the next edge occurs at least half a bit later.
- Reset mid-frame: returns to IDLE within the reset assertion. DESER_EN drops, so the paralleliser also clears.
- Strobes are mutually exclusive with DATA_VALID: DATA_VALID=1 implies PAR_ERR=STP_ERR=0.
- RX_DATA holds its value until the next DONE. On an error frame RX_DATA is still updated, but DATA_VALID stays 0.
- Latency: DATA_VALID asserts 2 CLK after the RX_tick at stop-bit mid-sample. That is 1 cycle for the STOP→DONE register plus 1 cycle for the output register.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE), 3-bit encoding.
  - PAR_EVEN/PAR_ODD constants.
  - default OVERSAMPLE and the MID_TICK and LAST_TICK constants.
- One natural sub-module: uart_sync, an SYNC_STAGES-deep synchroniser that outputs SER_BIT. It is reusable by the TX-side loopback.
- Parity computation stays inline.

Test Plan:
- Frame 0xA5, PAR_EN=0, stop=1, OVERSAMPLE=16 → DESER_EN high for the data phase only, DATA_VALID one cycle, RX_DATA=0xA5, no errors.
- 0x3C with PAR_EN=1, PAR_TYP=0 and parity bit 0 → DATA_VALID, RX_DATA=0x3C. Repeat with parity bit 1 → PAR_ERR=1, DATA_VALID=0.
- 0x01, odd parity, stop bit 0 → STP_ERR=1. Line is then held low for 20 bits with no new START; raise the line, then send 0x55 → DATA_VALID, RX_DATA=0x55.
- Low glitch on RX_IN lasting 4 ticks → START entered, abort at tick 7, back to IDLE, DESER_EN never rises, no strobes.
- Two back-to-back frames 0xFF then 0x00, the second start bit immediately after the stop bit → two DATA_VALID strobes with the correct bytes.
- RST asserted during DATA of 0x81 → all outputs at reset values asynchronously. The next frame, 0x7E, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity selectors, oversampling constants
// and the frame parity helper used by the RX controller.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int         OVERSAMPLE_DEF = 16;
    localparam logic [3:0] MID_TICK       = 4'd7;
    localparam logic [3:0] LAST_TICK      = 4'd15;

    // Parity bit the transmitter should have sent for this byte.
    function automatic logic exp_parity(input logic [7:0] data, input logic par_typ);
        logic x;
        x = ^data;
        if (par_typ == PAR_ODD) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX controller, the oversample tick source,
// the paralleliser and the host side.
interface uart_rx_ctrl_if;
    logic       RX_IN;
    logic       RX_tick;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       PARALLELISER_DONE;
    logic [7:0] PARALLEL_DATA;
    logic       SER_BIT;
    logic       DESER_EN;
    logic [7:0] RX_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       BUSY;

    modport slave (
        input  RX_IN, RX_tick, PAR_EN, PAR_TYP, PARALLELISER_DONE, PARALLEL_DATA,
        output SER_BIT, DESER_EN, RX_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );

    modport master (
        output RX_IN, RX_tick, PAR_EN, PAR_TYP, PARALLELISER_DONE, PARALLEL_DATA,
        input  SER_BIT, DESER_EN, RX_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial line.
// Flops reset to 1 so a reset never looks like a start bit.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw line into the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b1}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start-bit qualification, paralleliser
// enable, parity and stop checks, registered byte and result strobes.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_ctrl_if.slave  bus
);
    localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

    logic       ser_bit_s;
    logic       fall_s;

    state_t     state_q,    state_d;
    logic [3:0] tick_q,     tick_d;
    logic       ser_dly_q;
    logic       par_en_q,   par_en_d;
    logic       par_typ_q,  par_typ_d;
    logic       par_bad_q,  par_bad_d;
    logic       stp_bad_q,  stp_bad_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       deser_en_q, deser_en_d;
    logic       dv_q,       dv_d;
    logic       pe_q,       pe_d;
    logic       se_q,       se_d;
    logic       busy_q,     busy_d;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (bus.RX_IN),
        .q     (ser_bit_s)
    );

    assign fall_s = ser_dly_q & ~ser_bit_s;

    // Frame FSM next-state and output decode.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_bad_d  = par_bad_q;
        stp_bad_d  = stp_bad_q;
        rx_data_d  = rx_data_q;
        deser_en_d = deser_en_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (bus.RX_tick) begin
            tick_d = tick_q + 4'd1;
        end else begin
            tick_d = tick_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d   = ST_START;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bus.RX_tick && tick_q == MID && ser_bit_s) begin
                    state_d = ST_IDLE;
                end else if (bus.RX_tick && tick_q == LAST) begin
                    state_d    = ST_DATA;
                    deser_en_d = 1'b1;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                deser_en_d = 1'b1;
                if (bus.PARALLELISER_DONE) begin
                    rx_data_d  = bus.PARALLEL_DATA;
                    deser_en_d = 1'b0;
                    state_d    = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bus.RX_tick && tick_q == MID) begin
                    par_bad_d = (ser_bit_s != exp_parity(rx_data_q, par_typ_q));
                end else if (bus.RX_tick && tick_q == LAST) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leave at mid-bit so a start bit straight after the stop bit is caught.
                if (bus.RX_tick && tick_q == MID) begin
                    stp_bad_d = ~ser_bit_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_DONE: begin
                dv_d      = ~par_bad_q & ~stp_bad_q;
                pe_d      = par_bad_q;
                se_d      = stp_bad_q;
                par_bad_d = 1'b0;
                stp_bad_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                deser_en_d = 1'b0;
                par_bad_d  = 1'b0;
                stp_bad_d  = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            tick_d = 4'd0;
        end else begin
            tick_d = tick_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            tick_q     <= 4'd0;
            ser_dly_q  <= 1'b1;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stp_bad_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            deser_en_q <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            ser_dly_q  <= ser_bit_s;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bad_q  <= par_bad_d;
            stp_bad_q  <= stp_bad_d;
            rx_data_q  <= rx_data_d;
            deser_en_q <= deser_en_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.SER_BIT    = ser_bit_s;
    assign bus.DESER_EN   = deser_en_q;
    assign bus.RX_DATA    = rx_data_q;
    assign bus.DATA_VALID = dv_q;
    assign bus.PAR_ERR    = pe_q;
    assign bus.STP_ERR    = se_q;
    assign bus.BUSY       = busy_q;
endmodule
